fetch_pc_gen: RTL and testbench

Fetch-stage PC generator with a direct-mapped branch target buffer (BTB). It sits directly upstream of the conditional-branch controller. Each cycle it holds the fetch PC and predicts the next PC, then sends the prediction downstream as pred_taken, pred_pc and pred_adder. It accepts the corrected next PC and the active-low flush back from the branch controller, and BTB training from the execute stage.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/btb_array.sv | 69 ++++++
 rtl/fetch_pc_gen.sv | 91 +++++++++
 tb/tb_fetch_pc_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch PC generator and its branch target buffer.
// The entry layout is sized from the package constants, which match the top-level defaults.
package fetch_pkg;

    localparam int WORD_SIZE   = 32;
    localparam int BTB_ENTRIES = 16;
    localparam int IDX_BITS    = $clog2(BTB_ENTRIES);
    localparam int TAG_BITS    = WORD_SIZE - IDX_BITS - 2;

    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [TAG_BITS-1:0]   tag;
        logic [WORD_SIZE-1:0]  target;
        logic [1:0]            ctr;
    } btb_entry_t;

    // Two-bit saturating direction counter.
    function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] result;
        result = ctr;
        if (taken) begin
            if (ctr != 2'b11) result = 2'(ctr + 2'd1);
        end else begin
            if (ctr != 2'b00) result = 2'(ctr - 2'd1);
        end
        return result;
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: one combinational read port and one registered training port.
// Reads always return the contents before this cycle's update (read-before-write).
module btb_array
    import fetch_pkg::*;
#(
    parameter int  WordSize   = WORD_SIZE,
    parameter int  BtbEntries = BTB_ENTRIES,
    localparam int IdxBits    = $clog2(BtbEntries),
    localparam int TagBits    = WordSize - IdxBits - 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [IdxBits-1:0]  rd_idx,
    output btb_entry_t          rd_entry,
    input  logic                upd_valid,
    input  logic [WordSize-1:0] upd_pc,
    input  logic [WordSize-1:0] upd_target,
    input  logic                upd_taken
);

    btb_entry_t         entry_q [BtbEntries];
    logic [IdxBits-1:0] upd_idx;
    logic [TagBits-1:0] upd_tag;
    logic               unused_upd_lsb;

    assign upd_idx        = upd_pc[IdxBits+1:2];
    assign upd_tag        = upd_pc[WordSize-1:IdxBits+2];
    assign unused_upd_lsb = ^upd_pc[1:0];
    assign rd_entry       = entry_q[rd_idx];

    generate
        for (genvar gi = 0; gi < BtbEntries; gi++) begin : g_entry
            btb_entry_t entry_reg;
            btb_entry_t entry_next;
            logic       upd_hit;

            assign entry_q[gi] = entry_reg;
            assign upd_hit     = entry_reg.valid && (entry_reg.tag == upd_tag);

            always_comb begin
                entry_next = entry_reg;
                if (upd_valid && (upd_idx == IdxBits'(gi))) begin
                    if (upd_hit) begin
                        entry_next.ctr = sat_ctr_next(entry_reg.ctr, upd_taken);
                        if (upd_taken) entry_next.target = upd_target;
                    end else if (upd_taken) begin
                        // Not-taken misses are not worth a slot; only taken branches allocate.
                        entry_next.valid  = 1'b1;
                        entry_next.tag    = upd_tag;
                        entry_next.target = upd_target;
                        entry_next.ctr    = CTR_WT;
                    end
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    entry_reg.valid  <= 1'b0;
                    entry_reg.tag    <= '0;
                    entry_reg.target <= '0;
                    entry_reg.ctr    <= CTR_WNT;
                end else begin
                    entry_reg <= entry_next;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC register with BTB-based next-PC prediction.
// Redirects from the branch controller take priority over stalls.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int                   WordSize    = WORD_SIZE,
    parameter int                   BtbEntries  = BTB_ENTRIES,
    parameter logic [WordSize-1:0]  ResetVector = '0,
    localparam int                  IdxBits     = $clog2(BtbEntries),
    localparam int                  TagBits     = WordSize - IdxBits - 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                stall,
    input  logic                flush_n,
    input  logic [WordSize-1:0] redirect_pc,
    input  logic                upd_valid,
    input  logic [WordSize-1:0] upd_pc,
    input  logic [WordSize-1:0] upd_target,
    input  logic                upd_taken,
    output logic [WordSize-1:0] pc,
    output logic                pred_taken,
    output logic [WordSize-1:0] pred_adder,
    output logic [WordSize-1:0] pred_pc,
    output logic                fetch_valid
);

    logic [WordSize-1:0] pc_reg;
    logic [WordSize-1:0] pc_next;
    logic [WordSize-1:0] pc_plus4;
    logic                started_reg;
    logic [IdxBits-1:0]  lookup_idx;
    logic [TagBits-1:0]  lookup_tag;
    logic                btb_hit;
    btb_entry_t          rd_entry;

    assign lookup_idx = pc_reg[IdxBits+1:2];
    assign lookup_tag = pc_reg[WordSize-1:IdxBits+2];
    assign pc_plus4   = pc_reg + WordSize'(4);

    btb_array #(
        .WordSize   (WordSize),
        .BtbEntries (BtbEntries)
    ) u_btb (
        .clk        (clk),
        .rstn       (rstn),
        .rd_idx     (lookup_idx),
        .rd_entry   (rd_entry),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken)
    );

    assign btb_hit    = rd_entry.valid && (rd_entry.tag == lookup_tag);
    assign pred_taken = btb_hit && rd_entry.ctr[1];

    // pred_pc carries the path not chosen so the controller can recover on a mispredict.
    always_comb begin
        pred_adder = pc_plus4;
        pred_pc    = pc_plus4;
        if (pred_taken) begin
            pred_adder = rd_entry.target;
        end else if (btb_hit) begin
            pred_pc = rd_entry.target;
        end
    end

    always_comb begin
        pc_next = pred_adder;
        if (!flush_n) begin
            pc_next = redirect_pc & ~WordSize'(3);
        end else if (stall) begin
            pc_next = pc_reg;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_reg      <= ResetVector;
            started_reg <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            started_reg <= 1'b1;
        end
    end

    assign pc          = pc_reg;
    assign fetch_valid = started_reg & flush_n;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios then random traffic against a reference model.
module tb_fetch_pc_gen;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall;
    logic        flush_n;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_adder;
    logic [31:0] pred_pc;
    logic        fetch_valid;

    int total = 0;
    int bad   = 0;

    // Reference state: BTB kept as plain arrays, counter as an integer 0..3.
    bit          m_valid [N];
    int unsigned m_tag   [N];
    int unsigned m_tgt   [N];
    int          m_ctr   [N];
    int unsigned m_pc;
    bit          m_started;

    fetch_pc_gen dut (
        .clk         (clk),
        .rstn        (rstn),
        .stall       (stall),
        .flush_n     (flush_n),
        .redirect_pc (redirect_pc),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .pc          (pc),
        .pred_taken  (pred_taken),
        .pred_adder  (pred_adder),
        .pred_pc     (pred_pc),
        .fetch_valid (fetch_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (pc=%h t=%0t)", tag, got, exp, pc, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 1;
        end
        m_pc      = 0;
        m_started = 1'b0;
    endtask

    task automatic model_pred(output bit t, output int unsigned adder, output int unsigned alt);
        int          i;
        bit          hit;
        int unsigned seq;
        i     = int'((m_pc / 4) % N);
        hit   = m_valid[i] && (m_tag[i] == m_pc / (4 * N));
        seq   = m_pc + 4;
        t     = hit && (m_ctr[i] >= 2);
        adder = t ? m_tgt[i] : seq;
        alt   = t ? seq : (hit ? m_tgt[i] : seq);
    endtask

    task automatic check_outs();
        bit          t;
        int unsigned adder, alt;
        model_pred(t, adder, alt);
        chk("pc", pc, m_pc);
        chk("fetch_valid", fetch_valid, m_started & flush_n);
        chk("pred_taken", pred_taken, t);
        chk("pred_adder", pred_adder, adder);
        chk("pred_pc", pred_pc, alt);
    endtask

    // Called at a falling edge: drive inputs, check, advance the model, and move to the next falling edge.
    task automatic step(input logic s, input logic f, input logic [31:0] r,
                        input logic uv, input logic [31:0] up, input logic [31:0] ut,
                        input logic tk);
        bit          t;
        int unsigned adder, alt;
        int          i;
        stall = s; flush_n = f; redirect_pc = r;
        upd_valid = uv; upd_pc = up; upd_target = ut; upd_taken = tk;
        #1;
        check_outs();
        model_pred(t, adder, alt);
        if (uv) begin
            i = int'((up / 4) % N);
            if (m_valid[i] && m_tag[i] == up / (4 * N)) begin
                m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                if (tk) m_tgt[i] = ut;
            end else if (tk) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = up / (4 * N);
                m_tgt[i]   = ut;
                m_ctr[i]   = 2;
            end
        end
        if (!f)         m_pc = r & 32'hFFFF_FFFC;
        else if (!s)    m_pc = adder;
        m_started = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic redirect(input logic [31:0] r);
        step(1'b0, 1'b0, r, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Reset asserted mid-run while a taken update is pending; the update must be discarded.
    task automatic do_reset();
        rstn = 1'b0; flush_n = 1'b1; stall = 1'b0;
        upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h10; upd_target = 32'h99C;
        #1;
        model_reset();
        check_outs();
        @(posedge clk);
        @(negedge clk);
        check_outs();
        rstn = 1'b1;
        upd_valid = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; stall = 1'b0; flush_n = 1'b1; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_outs();
        chk("rst_pred_pc", pred_pc, 32'h4);
        @(negedge clk);
        rstn = 1'b1;

        // Sequential fetch 0x0, 0x4, 0x8; train 0x10 -> 0x40 taken while at 0x8.
        idle();
        idle();
        step(1'b0, 1'b1, 32'h0, 1'b1, 32'h10, 32'h40, 1'b1);
        idle();
        #1;
        chk("train_pc", pc, 32'h10);
        chk("train_taken", pred_taken, 1'b1);
        chk("train_adder", pred_adder, 32'h40);
        chk("train_alt", pred_pc, 32'h14);
        idle();
        chk("train_next", pc, 32'h40);

        // Three not-taken updates walk the counter 10 -> 01 -> 00 -> 00.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'h0, 1'b1, 32'h10, 32'h0, 1'b0);
        redirect(32'h10);
        #1;
        chk("nt_taken", pred_taken, 1'b0);
        chk("nt_alt", pred_pc, 32'h40);
        chk("nt_adder", pred_adder, 32'h14);

        // Redirect wins over stall; low bits are dropped.
        step(1'b1, 1'b0, 32'h103, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("redir_pc", pc, 32'h100);

        // Stall at 0x20 for three cycles with a training update inside it.
        redirect(32'h20);
        step(1'b1, 1'b1, 32'h0, 1'b1, 32'h20, 32'h80, 1'b1);
        step(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("stall_pc", pc, 32'h20);
        chk("stall_taken", pred_taken, 1'b1);
        idle();
        chk("stall_next", pc, 32'h80);

        // Alias 0x50 onto the 0x10 slot; 0x10 then misses.
        step(1'b0, 1'b1, 32'h0, 1'b1, 32'h10 + 4 * N, 32'h60, 1'b1);
        redirect(32'h10);
        #1;
        chk("alias_taken", pred_taken, 1'b0);
        chk("alias_alt", pred_pc, 32'h14);

        // Top-of-memory wrap.
        redirect(32'hFFFF_FFFC);
        #1;
        chk("wrap_adder", pred_adder, 32'h0);
        idle();
        chk("wrap_pc", pc, 32'h0);

        // Random traffic over a small address pool so hits and aliases are frequent.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r, up, ut;
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                r  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                if ($urandom_range(0, 31) == 0) r = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                up = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
                ut = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
                step($urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0, r,
                     $urandom_range(0, 1) == 1, up, ut, $urandom_range(0, 1) == 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
